// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
// Receives 8N1 serial frames: one start bit (0), eight data bits sent LSB
// first, one stop bit (1), no parity. The line is synchronised, the start
// edge is detected, and then every bit is decided by a 2-of-3 vote taken
// around the middle of the bit period.
//
// Parameters
//   CLK_FREQ  : system clock frequency in Hz
//   BAUD_RATE : serial bit rate in bit/s
// Ports
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous reset, active low
//   rxd       in   asynchronous serial line, idles high
//   rx_flag   out  one-cycle pulse: rx_data holds a newly received byte
//   rx_data   out  last byte received with a valid stop bit
//   rx_err    out  one-cycle pulse: framing error (stop bit sampled low)
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       rxd,
   output logic       rx_flag,
   output logic [7:0] rx_data,
   output logic       rx_err
);

   localparam int BIT_CNT = CLK_FREQ / BAUD_RATE;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = $clog2(BIT_CNT);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] C_SMPA = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] C_SMPB = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(HALF + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic [1:0]       r_sync;
   logic             r_prev;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_samp_a;
   logic             r_samp_b;
   logic [7:0]       r_data;
   logic             r_flag;
   logic             r_err;

   state_t           w_state_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic [2:0]       w_bit_idx_next;
   logic [7:0]       w_shift_next;
   logic [7:0]       w_data_next;
   logic             w_flag_next;
   logic             w_err_next;
   logic             w_rxd_s;
   logic             w_fall;
   logic             w_maj;
   logic             w_at_last;
   logic             w_at_dec;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_rxd_s   = r_sync[1];
   assign w_fall    = r_prev & ~w_rxd_s;
   // Two earlier samples plus the live one: any single-cycle glitch is outvoted.
   assign w_maj     = (r_samp_a & r_samp_b) | (r_samp_a & w_rxd_s) | (r_samp_b & w_rxd_s);
   assign w_at_last = (r_cnt == C_LAST);
   assign w_at_dec  = (r_cnt == C_DEC);
   assign w_cnt_inc = w_at_last ? '0 : r_cnt + 1'b1;

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_data_next    = r_data;
      w_flag_next    = 1'b0;
      w_err_next     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_next = '0;
            if (w_fall) begin
               w_state_next   = S_START;
               w_bit_idx_next = 3'd0;
            end
         end
         S_START: begin
            w_cnt_next = w_cnt_inc;
            if (w_at_dec && w_maj) begin
               // Start bit did not hold low through mid-bit: treat as a glitch.
               w_state_next = S_IDLE;
               w_cnt_next   = '0;
            end else if (w_at_last) begin
               w_state_next   = S_DATA;
               w_bit_idx_next = 3'd0;
            end
         end
         S_DATA: begin
            w_cnt_next = w_cnt_inc;
            if (w_at_dec) begin
               w_shift_next[r_bit_idx] = w_maj;
            end
            if (w_at_last) begin
               if (r_bit_idx == 3'd7) begin
                  w_state_next   = S_STOP;
                  w_bit_idx_next = 3'd0;
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         S_STOP: begin
            w_cnt_next = w_cnt_inc;
            // Decide at mid stop bit and leave at once, so a start bit that
            // follows immediately is still caught from IDLE.
            if (w_at_dec) begin
               w_cnt_next = '0;
               if (w_maj) begin
                  w_data_next  = r_shift;
                  w_flag_next  = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_err_next   = 1'b1;
                  w_state_next = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // A line stuck low after a framing error must not start a frame.
            w_cnt_next = '0;
            if (w_rxd_s) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_sync    <= 2'b11;
         r_prev    <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         r_samp_a  <= 1'b1;
         r_samp_b  <= 1'b1;
         r_data    <= 8'h00;
         r_flag    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], rxd};
         r_prev    <= w_rxd_s;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
         r_data    <= w_data_next;
         r_flag    <= w_flag_next;
         r_err     <= w_err_next;
         if (r_cnt == C_SMPA) r_samp_a <= w_rxd_s;
         if (r_cnt == C_SMPB) r_samp_b <= w_rxd_s;
      end
   end

   assign rx_flag = r_flag;
   assign rx_data = r_data;
   assign rx_err  = r_err;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx: bytes that should arrive are queued as frames
// are driven and compared when rx_flag pulses. Framing errors are counted
// against an expected count.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int BAUD_RATE = 115200;
   localparam int BIT_CNT   = CLK_FREQ / BAUD_RATE;
   localparam int HALF      = BIT_CNT / 2;
   localparam int EXP_LAT   = 9 * BIT_CNT + HALF + 2 + 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       rxd     = 1'b1;
   logic       rx_flag;
   logic [7:0] rx_data;
   logic       rx_err;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   int         lat_t0   = 0;
   bit         lat_armed = 1'b0;
   int         err_seen = 0;
   int         exp_err  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] prev_data = 8'h00;
   logic       prev_flag = 1'b0;
   logic       prev_err  = 1'b0;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD_RATE(BAUD_RATE)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .rxd    (rxd),
      .rx_flag(rx_flag),
      .rx_data(rx_data),
      .rx_err (rx_err)
   );

   always #10 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Monitor: compares outputs on the falling edge, away from DUT updates.
   always @(negedge sys_clk) begin
      if (rx_flag && rx_err) check("flag_and_err_same_cycle", 1, 0);
      if (rx_flag && prev_flag) check("flag_pulse_width", 2, 1);
      if (rx_err && prev_err) check("err_pulse_width", 2, 1);
      if (rx_flag) begin
         $display("rx byte 0x%02h at cycle %0d", rx_data, cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_flag", 1, 0);
         end else begin
            check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
         end
         if (lat_armed) begin
            lat_armed = 1'b0;
            check("latency_in_window",
                  ((cyc - lat_t0 - 1 >= EXP_LAT - 1) && (cyc - lat_t0 - 1 <= EXP_LAT + 1)) ? 1 : 0, 1);
         end
      end else if (sys_rst && rx_data !== prev_data) begin
         check("rx_data_hold", {24'd0, rx_data}, {24'd0, prev_data});
      end
      if (rx_err) begin
         err_seen++;
         $display("rx framing error at cycle %0d", cyc);
      end
      prev_data = rx_data;
      prev_flag = rx_flag;
      prev_err  = rx_err;
   end

   // Drives one frame. glitch_at inverts the line for one cycle at that frame
   // offset; rst_at pulses reset at that offset and abandons the frame.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int glitch_at, input int rst_at);
      logic v;
      for (int i = 0; i < 10 * BIT_CNT; i++) begin
         @(negedge sys_clk);
         if (i == rst_at) begin
            sys_rst = 1'b0;
            rxd     = 1'b1;
            repeat (5) @(negedge sys_clk);
            sys_rst = 1'b1;
            return;
         end
         case (i / BIT_CNT)
            0:       v = 1'b0;
            9:       v = stop_bit;
            default: v = b[(i / BIT_CNT) - 1];
         endcase
         if (i == glitch_at) v = ~v;
         rxd = v;
         if (i == 0) lat_t0 = cyc;
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         rxd = 1'b1;
      end
   endtask

   initial begin
      logic [7:0] b2b [4];
      b2b[0] = 8'h00; b2b[1] = 8'h01; b2b[2] = 8'h00; b2b[3] = 8'h02;

      // Reset values
      repeat (3) @(negedge sys_clk);
      check("reset_rx_flag", {31'd0, rx_flag}, 0);
      check("reset_rx_err", {31'd0, rx_err}, 0);
      check("reset_rx_data", {24'd0, rx_data}, 0);
      sys_rst = 1'b1;
      idle_cycles(50);

      // Single byte with latency measurement
      exp_q.push_back(8'h55);
      lat_armed = 1'b1;
      send_frame(8'h55, 1'b1, -1, -1);
      idle_cycles(100);
      check("after_55_queue_empty", exp_q.size(), 0);
      check("after_55_no_err", err_seen, 0);

      // Back-to-back frames, no idle between stop and next start
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(b2b[k]);
         send_frame(b2b[k], 1'b1, -1, -1);
      end
      idle_cycles(100);
      check("b2b_queue_empty", exp_q.size(), 0);

      // Short low pulse is rejected as a false start
      for (int i = 0; i < 100; i++) begin
         @(negedge sys_clk);
         rxd = 1'b0;
      end
      idle_cycles(BIT_CNT * 2);
      check("glitch_start_no_err", err_seen, 0);
      exp_q.push_back(8'hA3);
      send_frame(8'hA3, 1'b1, -1, -1);
      idle_cycles(100);
      check("a3_queue_empty", exp_q.size(), 0);

      // Framing error, then line held low
      exp_err++;
      send_frame(8'h3C, 1'b0, -1, -1);
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clk);
         rxd = 1'b0;
      end
      idle_cycles(BIT_CNT);
      check("framing_err_count", err_seen, exp_err);
      check("data_kept_after_err", {24'd0, rx_data}, 32'hA3);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, -1, -1);
      idle_cycles(100);
      check("ff_queue_empty", exp_q.size(), 0);

      // One-cycle inverted glitch on the centre sample of bit 3
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1, 4 * BIT_CNT + HALF + 1, -1);
      idle_cycles(100);
      check("glitch_0f_queue_empty", exp_q.size(), 0);

      // Reset during bit 4 of 0x81 aborts the frame
      send_frame(8'h81, 1'b1, -1, 5 * BIT_CNT + 100);
      idle_cycles(BIT_CNT * 2);
      check("abort_rx_data_cleared", {24'd0, rx_data}, 0);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, -1, -1);
      idle_cycles(100);
      check("7e_queue_empty", exp_q.size(), 0);
      check("final_rx_data", {24'd0, rx_data}, 32'h7E);
      check("final_err_count", err_seen, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #(20 * 120_000);
      $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_flag  output  1  one-cycle pulse: rx_data holds a newly received valid byte.
REQ-007 SHALL have port rx_data  output  8  last valid received byte.
REQ-008 SHALL have port rx_err  output  1  one-cycle pulse: framing error, stop bit sampled low.

Function
REQ-009 SHALL accept frames of 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-010 SHALL derive BIT_CNT = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults) and HALF = BIT_CNT/2 (217).
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: on falling edge of rxd_s (previous 1, current 0), SHALL go to START with baud counter cleared to 0.
REQ-014 Baud counter SHALL count 0..BIT_CNT-1 and wrap to 0 in START, DATA and STOP; held at 0 in IDLE and WAIT_HIGH.
REQ-015 Each bit SHALL be decided by 2-of-3 majority of rxd_s sampled at counter HALF-1, HALF, HALF+1; decision taken at counter HALF+1.
REQ-016 START: majority 0 -> continue, enter DATA at counter wrap with bit index 0; majority 1 -> glitch, return to IDLE immediately, no flag, no error.
REQ-017 DATA: at each decision, bit SHALL be stored into internal shift register position bit index; at wrap, bit index increments; at wrap with bit index 7 -> STOP.
REQ-018 STOP: majority 1 -> rx_data loaded from shift register and rx_flag high for exactly the next cycle, state returns to IDLE in that same cycle (no wait for end of stop bit).
REQ-019 STOP: majority 0 -> rx_err high for exactly one cycle, rx_data unchanged, state to WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL stay until rxd_s = 1, then go to IDLE; falling edges during WAIT_HIGH SHALL be ignored.
REQ-021 rx_flag and rx_err SHALL never be high in the same cycle, and each SHALL be high at most once per frame.
REQ-022 rx_data SHALL change only in the cycle rx_flag is asserted and hold otherwise.
REQ-023 rx_flag SHALL assert 9*BIT_CNT + HALF + 2 cycles (+2 synchronizer) after the rxd falling edge, ±1 cycle edge-alignment uncertainty.
REQ-024 Back-to-back frames (next start bit directly after stop bit) SHALL be received without loss.
REQ-025 rx_flag/rx_data SHALL match the consumer protocol: flag one sys_clk wide, data valid in the flag cycle and after.

Reset
REQ-026 On sys_rst low, asynchronously: state IDLE, counters 0, bit index 0, shift register 0x00, rx_data 0x00, rx_flag 0, rx_err 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no flag or error; after release, reception restarts at the next falling edge.

Verification
REQ-028 Send 0x55 at 115200 with 50 MHz clock -> one rx_flag pulse, rx_data = 0x55, rx_err stays 0.
REQ-029 Send 0x00, 0x01, 0x00, 0x02 back-to-back -> four rx_flag pulses, rx_data sequence 0x00, 0x01, 0x00, 0x02.
REQ-030 Drive rxd low for 100 cycles then high -> no rx_flag, no rx_err, state back to IDLE; following 0xA3 received correctly.
REQ-031 Send 0x3C with stop bit forced 0, line then held low 2000 cycles -> one rx_err pulse, no rx_flag, rx_data unchanged; next 0xFF received after line returns high.
REQ-032 Single-cycle inverted glitch at mid-sample of bit 3 of 0x0F -> rx_data = 0x0F (majority filter).
REQ-033 Assert sys_rst during bit 4 of 0x81, release, send 0x7E -> no output for the aborted frame, rx_data = 0x7E with one rx_flag.
